// File: rtl/weight_buffer_loader.sv
// Streams 32-bit words into 512-bit lines and writes each packed line into a
// single-port weight buffer at consecutive (wrapping) line addresses.
module weight_buffer_loader #(
    parameter int WORDS_PER_LINE = 16,
    parameter int DEPTH          = 64
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    input  logic                         start,
    input  logic [$clog2(DEPTH)-1:0]     base_addr,
    input  logic [$clog2(DEPTH):0]       num_lines,
    input  logic                         abort,
    input  logic                         s_valid,
    input  logic [31:0]                  s_data,
    output logic                         s_ready,
    output logic                         CEN,
    output logic                         WEN,
    output logic [$clog2(DEPTH)-1:0]     A,
    output logic [32*WORDS_PER_LINE-1:0] D,
    output logic                         RETN,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LCW = AW + 1;
    localparam int WCW = $clog2(WORDS_PER_LINE);
    localparam int LW  = 32 * WORDS_PER_LINE;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   word_cnt_q, word_cnt_d;
    logic [LCW-1:0]   line_cnt_q, line_cnt_d;
    logic [LCW-1:0]   num_q, num_d;
    logic [AW-1:0]    base_q, base_d;
    logic             s_ready_q, s_ready_d;
    logic             cen_q, cen_d;
    logic             wen_q, wen_d;
    logic [AW-1:0]    a_q, a_d;
    logic [LW-1:0]    d_q, d_d;
    logic             retn_q;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [LW-1:0]    pack_q, pack_d;
    logic             xfer;
    logic             last_word;
    logic             legal_len;

    // abort wins over a coincident stream word, so a cancelled word is never packed
    assign xfer      = s_valid & s_ready_q & ~abort;
    assign last_word = (word_cnt_q == WCW'(WORDS_PER_LINE - 1));
    assign legal_len = (num_lines != '0) && (num_lines <= LCW'(DEPTH));

    always_comb begin
        pack_d = pack_q;
        if (xfer) begin
            for (int k = 0; k < WORDS_PER_LINE; k++) begin
                if (word_cnt_q == WCW'(k)) begin
                    pack_d[32*k +: 32] = s_data;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        line_cnt_d = line_cnt_q;
        num_d      = num_q;
        base_d     = base_q;
        s_ready_d  = 1'b0;
        cen_d      = 1'b1;
        wen_d      = 1'b1;
        a_d        = a_q;
        d_d        = d_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (start && legal_len) begin
                    state_d    = FILL;
                    base_d     = base_addr;
                    num_d      = num_lines;
                    word_cnt_d = '0;
                    line_cnt_d = '0;
                    s_ready_d  = 1'b1;
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                end else if (start) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            FILL: begin
                if (abort) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    s_ready_d = 1'b1;
                    if (xfer && last_word) begin
                        state_d    = WRITE;
                        s_ready_d  = 1'b0;
                        word_cnt_d = '0;
                    end else if (xfer) begin
                        word_cnt_d = word_cnt_q + WCW'(1);
                    end
                end
            end
            WRITE: begin
                // the buffer strobe is issued from here so a same-cycle abort can still veto it
                if (abort) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cen_d      = 1'b0;
                    wen_d      = 1'b0;
                    a_d        = base_q + line_cnt_q[AW-1:0];
                    d_d        = pack_q;
                    line_cnt_d = line_cnt_q + LCW'(1);
                    if (line_cnt_q + LCW'(1) == num_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d    = FILL;
                        s_ready_d  = 1'b1;
                        word_cnt_d = '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            line_cnt_q <= '0;
            num_q      <= '0;
            base_q     <= '0;
            s_ready_q  <= 1'b0;
            cen_q      <= 1'b1;
            wen_q      <= 1'b1;
            a_q        <= '0;
            d_q        <= '0;
            retn_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            line_cnt_q <= line_cnt_d;
            num_q      <= num_d;
            base_q     <= base_d;
            s_ready_q  <= s_ready_d;
            cen_q      <= cen_d;
            wen_q      <= wen_d;
            a_q        <= a_d;
            d_q        <= d_d;
            retn_q     <= 1'b1;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // packing register is pure datapath; its contents only matter once a full line is in
    always_ff @(posedge CLK) begin
        pack_q <= pack_d;
    end

    assign s_ready = s_ready_q;
    assign CEN     = cen_q;
    assign WEN     = wen_q;
    assign A       = a_q;
    assign D       = d_q;
    assign RETN    = retn_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_weight_buffer_loader.sv
// Scoreboard bench for weight_buffer_loader: directed loads push expected
// buffer writes and done/err results; a negedge monitor pops and compares.
module tb_weight_buffer_loader;

    logic         CLK;
    logic         RSTN;
    logic         start;
    logic [5:0]   base_addr;
    logic [6:0]   num_lines;
    logic         abort;
    logic         s_valid;
    logic [31:0]  s_data;
    logic         s_ready;
    logic         CEN;
    logic         WEN;
    logic [5:0]   A;
    logic [511:0] D;
    logic         RETN;
    logic         busy;
    logic         done;
    logic         err;

    weight_buffer_loader #(.WORDS_PER_LINE(16), .DEPTH(64)) dut (
        .CLK(CLK), .RSTN(RSTN), .start(start), .base_addr(base_addr),
        .num_lines(num_lines), .abort(abort), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .CEN(CEN), .WEN(WEN), .A(A), .D(D), .RETN(RETN),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct packed {
        logic [5:0]   a;
        logic [511:0] d;
    } wr_t;

    wr_t wq[$];
    bit  dq[$];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int first_cyc = 0;
    int last_done_cyc = 0;
    wr_t mon_e;
    bit  mon_err;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    always @(negedge CLK) begin
        if (RSTN === 1'b1) begin
            if (CEN !== 1'b1) begin
                if (wq.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL unexpected_write: got A=%0d CEN=%b expected no write", A, CEN);
                end else begin
                    mon_e = wq.pop_front();
                    chk("write_addr", 512'(A), 512'(mon_e.a));
                    chk("write_data", D, mon_e.d);
                    chk("write_wen", 512'(WEN), 512'(0));
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                last_done_cyc = cyc;
                if (dq.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected none");
                end else begin
                    mon_err = dq.pop_front();
                    chk("done_err", 512'(err), 512'(mon_err));
                    chk("done_busy", 512'(busy), 512'(0));
                end
            end
        end
    end

    task automatic push_writes(input logic [5:0] base, input int n, input logic [31:0] seed);
        wr_t e;
        for (int l = 0; l < n; l++) begin
            e.a = base + 6'(l);
            for (int k = 0; k < 16; k++) e.d[32*k +: 32] = seed + 32'(16*l + k);
            wq.push_back(e);
        end
    endtask

    task automatic issue_start(input logic [5:0] base, input logic [6:0] nl);
        @(negedge CLK);
        start = 1'b1;
        base_addr = base;
        num_lines = nl;
        @(negedge CLK);
        start = 1'b0;
        num_lines = 7'd0;
    endtask

    // drives words seed+i; gaps come from a fixed pattern; stray puts a start in mid-load
    task automatic feed(input logic [31:0] seed, input int nwords, input bit gaps, input bit stray);
        int i = 0;
        int t = 0;
        bit gap;
        while (i < nwords && t < 3000) begin
            gap = gaps && ((t % 5 == 2) || (t % 7 == 3));
            start = stray && (t == 10);
            if (!gap && s_ready === 1'b1) begin
                s_valid = 1'b1;
                s_data = seed + 32'(i);
                if (i == 0) first_cyc = cyc;
                i++;
            end else begin
                s_valid = 1'b0;
                s_data = 32'hDEAD_BEEF;
            end
            @(negedge CLK);
            t++;
        end
        start = 1'b0;
        s_valid = 1'b0;
        if (i < nwords) begin
            n_assert++;
            n_fail++;
            $display("FAIL feed_timeout: got %0d words expected %0d", i, nwords);
        end
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < 3000) begin
            @(negedge CLK);
            t++;
        end
        chk("done_seen", 512'(done_cnt >= target), 512'(1));
        @(negedge CLK);
    endtask

    initial begin
        RSTN = 1'b0;
        start = 1'b0;
        base_addr = '0;
        num_lines = '0;
        abort = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        #12;
        chk("rst_cen", 512'(CEN), 512'(1));
        chk("rst_wen", 512'(WEN), 512'(1));
        chk("rst_retn", 512'(RETN), 512'(0));
        chk("rst_sready", 512'(s_ready), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_done_err", 512'({done, err}), 512'(0));
        chk("rst_a_d", 512'({A, D[15:0]}), 512'(0));
        @(negedge CLK);
        RSTN = 1'b1;
        #1 chk("retn_before_edge", 512'(RETN), 512'(0));
        @(negedge CLK);
        chk("retn_after_edge", 512'(RETN), 512'(1));

        // one line, base 0, words 0x00..0x0F back-to-back
        issue_start(6'd0, 7'd1);
        chk("busy_after_start", 512'(busy), 512'(1));
        push_writes(6'd0, 1, 32'h0);
        dq.push_back(1'b0);
        feed(32'h0, 16, 1'b0, 1'b0);
        wait_done(1);
        chk("latency_1line", 512'(last_done_cyc - first_cyc), 512'(17));

        // illegal lengths finish with err and never touch the buffer
        dq.push_back(1'b1);
        issue_start(6'd7, 7'd0);
        wait_done(2);
        dq.push_back(1'b1);
        issue_start(6'd7, 7'd65);
        wait_done(3);

        // wrapping addresses with stalls and an ignored start mid-load
        issue_start(6'd62, 7'd4);
        chk("err_cleared_on_start", 512'(err), 512'(0));
        push_writes(6'd62, 4, 32'hC0DE_0000);
        dq.push_back(1'b0);
        feed(32'hC0DE_0000, 64, 1'b1, 1'b1);
        wait_done(4);
        chk("latency_min_4line", 512'(last_done_cyc - first_cyc >= 68), 512'(1));

        // abort after 7 words of the second line
        issue_start(6'd10, 7'd3);
        push_writes(6'd10, 1, 32'h5500_0000);
        dq.push_back(1'b1);
        feed(32'h5500_0000, 23, 1'b0, 1'b0);
        abort = 1'b1;
        s_valid = 1'b1;
        s_data = 32'h1111_2222;
        @(negedge CLK);
        abort = 1'b0;
        s_valid = 1'b0;
        chk("abort_fill_done", 512'(done), 512'(1));
        chk("abort_fill_err", 512'(err), 512'(1));
        chk("abort_fill_sready", 512'(s_ready), 512'(0));
        wait_done(5);

        // abort landing on the write cycle suppresses that write
        issue_start(6'd20, 7'd2);
        dq.push_back(1'b1);
        feed(32'h7700_0000, 16, 1'b0, 1'b0);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        chk("abort_write_done", 512'(done), 512'(1));
        chk("abort_write_cen", 512'(CEN), 512'(1));
        wait_done(6);

        // reset in the middle of a fill, then a normal load
        issue_start(6'd30, 7'd2);
        feed(32'h9900_0000, 5, 1'b0, 1'b0);
        #2 RSTN = 1'b0;
        #1;
        chk("midrst_cen_wen", 512'({CEN, WEN}), 512'(3));
        chk("midrst_retn", 512'(RETN), 512'(0));
        chk("midrst_sready_busy", 512'({s_ready, busy}), 512'(0));
        chk("midrst_a", 512'(A), 512'(0));
        @(negedge CLK);
        RSTN = 1'b1;
        #1 chk("rel_retn_low", 512'(RETN), 512'(0));
        @(negedge CLK);
        chk("rel_retn_high", 512'(RETN), 512'(1));
        issue_start(6'd5, 7'd1);
        push_writes(6'd5, 1, 32'hABCD_0100);
        dq.push_back(1'b0);
        feed(32'hABCD_0100, 16, 1'b0, 1'b0);
        wait_done(7);

        repeat (5) @(negedge CLK);
        chk("writes_drained", 512'(wq.size()), 512'(0));
        chk("dones_drained", 512'(dq.size()), 512'(0));
        chk("done_pulses", 512'(done_cnt), 512'(7));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/weight_buffer_loader.md
WEIGHT_BUFFER_LOADER -- requirements
Module: weight_buffer_loader

Interface
REQ-001 SHALL have parameter WORDS_PER_LINE, default 16, number of 32-bit stream words packed per 512-bit buffer line (fixed at 16 in this revision).
REQ-002 SHALL have parameter DEPTH, default 64, number of weight buffer lines (6-bit address).
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RSTN  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 base_addr  input  6  first buffer line to write; sampled with start.
REQ-007 num_lines  input  7  lines to load, legal 1..64; sampled with start.
REQ-008 abort  input  1  synchronous cancel of the load in progress.
REQ-009 s_valid  input  1  stream word valid.
REQ-010 s_data  input  32  stream word.
REQ-011 s_ready  output  1  loader accepts s_data this cycle.
REQ-012 CEN  output  1  buffer chip enable, active-low.
REQ-013 WEN  output  1  buffer write enable, active-low.
REQ-014 A  output  6  buffer line address.
REQ-015 D  output  512  buffer write data.
REQ-016 RETN  output  1  buffer retention enable; 1 = buffer operational.
REQ-017 busy  output  1  load in progress.
REQ-018 done  output  1  one-cycle pulse at the end of a load.
REQ-019 err  output  1  qualifies done; 1 = illegal num_lines or abort.

Function
REQ-020 FSM states SHALL be IDLE, FILL, WRITE, DONE; all outputs registered.
REQ-021 IDLE: start=1 with num_lines in 1..64 -> FILL, latch base_addr and num_lines, clear word and line counters, busy=1 from next cycle.
REQ-022 IDLE: start=1 with num_lines=0 or >64 -> DONE with err=1; no buffer access.
REQ-023 start outside IDLE SHALL be ignored.
REQ-024 FILL: s_ready=1; a word transfers when s_valid&s_ready; word k (0..15) stored at D[32k+31:32k], k=0 first received.
REQ-025 FILL: on the 16th transfer -> WRITE; s_ready=0 from the next cycle; no word accepted outside FILL.
REQ-026 WRITE: exactly one cycle with CEN=0, WEN=0, A=(base_addr+line_count) mod 64, D=packed line; line_count then increments.
REQ-027 After WRITE: line_count==num_lines -> DONE, else FILL with word counter cleared.
REQ-028 Address SHALL wrap 63 -> 0; e.g. base 62, 4 lines writes 62, 63, 0, 1.
REQ-029 Outside WRITE: CEN=1, WEN=1, A holds last value, D holds last value.
REQ-030 DONE: done=1 for exactly one cycle, busy=0, then IDLE; err cleared when next load starts.
REQ-031 abort=1 in FILL or WRITE -> DONE with err=1 next cycle; a partial line is discarded and never written; an abort coinciding with WRITE suppresses that write.
REQ-032 abort in IDLE or DONE SHALL be ignored; abort has priority over s_valid on the same cycle.
REQ-033 Gaps in s_valid SHALL stall packing without data loss; minimum load latency = 17*num_lines cycles from first transfer to done.

Reset
REQ-034 RSTN=0 SHALL immediately force: state IDLE, s_ready=0, CEN=1, WEN=1, A=0, D=0, RETN=0, busy=0, done=0, err=0, counters 0.
REQ-035 RETN SHALL rise to 1 on the first CLK edge after RSTN deasserts and stay 1.
REQ-036 Reset mid-load SHALL abandon the load with no write; the buffer line in progress is unmodified.

Verification
REQ-037 start, base 0, num_lines 1, words 0x00..0x0F back-to-back -> one WRITE at A=0, D[31:0]=0x00, D[511:480]=0x0F, done at cycle 17 after first transfer, err=0.
REQ-038 base 62, num_lines 4, random s_valid gaps -> writes at A=62,63,0,1 in order, data matches stream, single done pulse.
REQ-039 num_lines 0 and num_lines 65 -> done=1, err=1, CEN stays 1 throughout.
REQ-040 abort after 7 words of line 2 -> no second WRITE, done=1 err=1 next cycle, s_ready=0.
REQ-041 RSTN asserted mid-FILL -> CEN=WEN=1, RETN=0 asynchronously; after release RETN=1 next edge, new start loads normally.
